bf_exec_core: RTL and testbench

//  Brainfuck instruction-execution core: fetches 8-bit ASCII opcodes from a sync code ROM and

---
 rtl/bf_pkg.sv | 37 +++
 rtl/bf_exec_core_if.sv | 24 ++
 rtl/bf_exec_core_decode.sv | 24 ++
 rtl/bf_exec_core.sv | 125 ++++++++++++
 tb/tb_bf_exec_core.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared opcode, state and width definitions for the Brainfuck execution core.
// The core, its bus interface and the opcode decoder all import this package.
package bf_pkg;

  localparam int AW = 9;
  localparam int DW = 8;

  localparam logic [DW-1:0] OP_INC   = 8'h2B;
  localparam logic [DW-1:0] OP_DEC   = 8'h2D;
  localparam logic [DW-1:0] OP_RIGHT = 8'h3E;
  localparam logic [DW-1:0] OP_LEFT  = 8'h3C;
  localparam logic [DW-1:0] OP_LOOP  = 8'h5B;
  localparam logic [DW-1:0] OP_END   = 8'h5D;
  localparam logic [DW-1:0] OP_HALT  = 8'h00;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'h0,
    ST_EXEC    = 4'h1,
    ST_SF_WAIT = 4'h2,
    ST_SF_CHK  = 4'h3,
    ST_SB_WAIT = 4'h4,
    ST_SB_CHK  = 4'h5,
    ST_HALT    = 4'hF
  } state_t;

  // One-hot opcode class; all-zero means the byte is a NOP.
  typedef struct packed {
    logic inc;
    logic dec;
    logic right;
    logic left;
    logic loop;
    logic fin;
    logic halt;
  } op_class_t;

endpackage

// File: rtl/bf_exec_core_if.sv
// Bus between the execution core and its code ROM / data RAM, plus the state probe.
// master = core side, slave = memory / observer side.
interface bf_exec_core_if;
  import bf_pkg::*;

  logic [DW-1:0] code_in;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr_code;
  logic [AW-1:0] addr_array;
  logic [DW-1:0] data_out;
  logic          write_rq;
  logic [3:0]    probe;

  modport master (
    input  code_in, data_in,
    output addr_code, addr_array, data_out, write_rq, probe
  );

  modport slave (
    output code_in, data_in,
    input  addr_code, addr_array, data_out, write_rq, probe
  );

endinterface

// File: rtl/bf_exec_core_decode.sv
// Combinational opcode classifier: maps an ASCII opcode byte onto a one-hot class.
// Bytes outside the instruction set (including '.' and ',') yield an all-zero class.
module bf_exec_core_decode
  import bf_pkg::*;
(
  input  logic [DW-1:0] code,
  output op_class_t     cls
);

  always_comb begin
    cls = '0;
    case (code)
      OP_INC:   cls.inc   = 1'b1;
      OP_DEC:   cls.dec   = 1'b1;
      OP_RIGHT: cls.right = 1'b1;
      OP_LEFT:  cls.left  = 1'b1;
      OP_LOOP:  cls.loop  = 1'b1;
      OP_END:   cls.fin   = 1'b1;
      OP_HALT:  cls.halt  = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/bf_exec_core.sv
// Brainfuck execution core: two-cycle fetch/execute over a sync code ROM and data RAM,
// with bracket matching done by stepping the PC through the ROM while counting depth.
module bf_exec_core
  import bf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  bf_exec_core_if.master    bus
);

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] dp;
  logic [AW-1:0] depth;

  op_class_t     cls;
  logic          cell_zero;
  logic          pc_last;
  logic          pc_first;
  logic [AW-1:0] depth_fwd;
  logic [AW-1:0] depth_bwd;
  logic          do_write;

  bf_exec_core_decode u_decode (
    .code (bus.code_in),
    .cls  (cls)
  );

  assign cell_zero = (bus.data_in == '0);
  assign pc_last   = (pc == '1);
  assign pc_first  = (pc == '0);

  // Forward scan nests on '[' and unwinds on ']'; backward scan is the mirror image.
  assign depth_fwd = cls.loop ? depth + ONE : (cls.fin  ? depth - ONE : depth);
  assign depth_bwd = cls.fin  ? depth + ONE : (cls.loop ? depth - ONE : depth);

  // Write strobe is combinational so the RAM commits on the edge that ends EXEC,
  // and the following FETCH re-reads the freshly written cell.
  assign do_write     = reset && (state == ST_EXEC) && (cls.inc || cls.dec);
  assign bus.write_rq = do_write;
  assign bus.data_out = !do_write ? '0
                      : (cls.inc ? bus.data_in + 8'd1 : bus.data_in - 8'd1);

  assign bus.addr_code  = pc;
  assign bus.addr_array = dp;
  assign bus.probe      = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      dp    <= '0;
      depth <= '0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_EXEC;

        ST_EXEC: begin
          state <= ST_FETCH;
          if (cls.right) dp <= dp + ONE;
          if (cls.left)  dp <= dp - ONE;
          if (cls.halt) begin
            // PC ends one past the halt byte so the stop position is observable.
            state <= ST_HALT;
            if (!pc_last) pc <= pc + ONE;
          end else if (cls.fin && !cell_zero) begin
            depth <= ONE;
            if (pc_first) begin
              state <= ST_HALT;
            end else begin
              pc    <= pc - ONE;
              state <= ST_SB_WAIT;
            end
          end else begin
            if (cls.loop && cell_zero) begin
              depth <= ONE;
              state <= ST_SF_WAIT;
            end
            if (pc_last) state <= ST_HALT;
            else         pc    <= pc + ONE;
          end
        end

        ST_SF_WAIT: state <= ST_SF_CHK;

        ST_SF_CHK: begin
          depth <= depth_fwd;
          if (pc_last) begin
            state <= ST_HALT;
          end else begin
            pc    <= pc + ONE;
            state <= (depth_fwd == '0) ? ST_FETCH : ST_SF_WAIT;
          end
        end

        ST_SB_WAIT: state <= ST_SB_CHK;

        ST_SB_CHK: begin
          depth <= depth_bwd;
          if (depth_bwd == '0) begin
            // Resume just after the matching '['.
            if (pc_last) begin
              state <= ST_HALT;
            end else begin
              pc    <= pc + ONE;
              state <= ST_FETCH;
            end
          end else if (pc_first) begin
            state <= ST_HALT;
          end else begin
            pc    <= pc - ONE;
            state <= ST_SB_WAIT;
          end
        end

        ST_HALT: state <= ST_HALT;

        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_exec_core.sv
// Scoreboard bench for bf_exec_core: directed programs push expected RAM writes and
// halt positions into queues; a negedge monitor pops and compares as the core acts.
module tb_bf_exec_core;
  import bf_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic load  = 1'b0;

  always #5 clk = ~clk;

  bf_exec_core_if bus ();

  bf_exec_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rom     [512];
  logic [7:0] ram     [512];
  logic [7:0] ram_img [512];

  // Sync ROM and sync-read RAM with a separate write port.
  always @(posedge clk) begin
    bus.code_in <= rom[bus.addr_code];
    bus.data_in <= ram[bus.addr_array];
    if (load) begin
      for (int i = 0; i < 512; i++) ram[i] <= ram_img[i];
    end else if (bus.write_rq) begin
      ram[bus.addr_array] <= bus.data_out;
    end
  end

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [8:0] pc;
    logic [8:0] dp;
  } halt_t;

  wr_t   exp_wr   [$];
  halt_t exp_halt [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  wr_t        mon_wr;
  halt_t      mon_halt;
  logic [3:0] prev_probe = 4'h0;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.write_rq) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_wr = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.addr_array), 32'(mon_wr.addr));
          chk("wr_data", 32'(bus.data_out), 32'(mon_wr.data));
        end
      end else begin
        chk("data_out_idle", 32'(bus.data_out), 32'd0);
      end
      if (bus.probe == 4'hF && prev_probe != 4'hF) begin
        if (exp_halt.size() == 0) begin
          chk("unexpected_halt", 32'd1, 32'd0);
        end else begin
          mon_halt = exp_halt.pop_front();
          chk("halt_pc", 32'(bus.addr_code), 32'(mon_halt.pc));
          chk("halt_dp", 32'(bus.addr_array), 32'(mon_halt.dp));
        end
      end
      if (bus.probe == 4'hF) chk("halt_no_write", 32'(bus.write_rq), 32'd0);
    end
    prev_probe = bus.probe;
  end

  task automatic push_wr(input int addr, input int data);
    wr_t w;
    w.addr = 9'(addr);
    w.data = 8'(data);
    exp_wr.push_back(w);
  endtask

  task automatic push_halt(input int pc, input int dp);
    halt_t h;
    h.pc = 9'(pc);
    h.dp = 9'(dp);
    exp_halt.push_back(h);
  endtask

  task automatic clear_ram_img();
    for (int i = 0; i < 512; i++) ram_img[i] = 8'h00;
  endtask

  // Hold reset, load ROM/RAM, check reset outputs, then release at a negedge.
  task automatic boot(input string prog);
    reset = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) rom[i] = prog[i];
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    chk("rst_probe", 32'(bus.probe), 32'd0);
    chk("rst_pc", 32'(bus.addr_code), 32'd0);
    chk("rst_dp", 32'(bus.addr_array), 32'd0);
    chk("rst_write_rq", 32'(bus.write_rq), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input string name, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(posedge clk);
      #1 cyc++;
      if (bus.probe == 4'hF) break;
    end
    if (bus.probe != 4'hF) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: probe %0h after %0d cycles, required F", name, bus.probe, cyc);
    end
    @(negedge clk);
    #1;
    chk({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_halts_left"}, 32'(exp_halt.size()), 32'd0);
    exp_wr.delete();
    exp_halt.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nz;

    // "+++" halt: three increments of cell 0, halt entered on the 8th edge.
    clear_ram_img();
    push_wr(0, 1); push_wr(0, 2); push_wr(0, 3);
    push_halt(4, 0);
    boot("+++");
    run_to_halt("t_inc3", 50, cyc);
    chk("t_inc3_cycles", 32'(cyc), 32'd8);
    chk("t_inc3_cell0", 32'(ram[0]), 32'h03);
    chk("t_inc3_probe", 32'(bus.probe), 32'hF);

    // "-" on zero cell wraps to 0xFF.
    clear_ram_img();
    push_wr(0, 8'hFF);
    push_halt(2, 0);
    boot("-");
    run_to_halt("t_dec", 50, cyc);
    chk("t_dec_cell0", 32'(ram[0]), 32'hFF);

    // "<+" from DP=0 wraps the pointer to 511.
    clear_ram_img();
    push_wr(511, 1);
    push_halt(3, 511);
    boot("<+");
    run_to_halt("t_wrap", 50, cyc);
    chk("t_wrap_cell511", 32'(ram[511]), 32'h01);
    chk("t_wrap_cell0", 32'(ram[0]), 32'h00);

    // "++[>+<-]" moves cell 0 into cell 1 through a backward-scanned loop.
    clear_ram_img();
    push_wr(0, 1); push_wr(0, 2);
    push_wr(1, 1); push_wr(0, 1);
    push_wr(1, 2); push_wr(0, 0);
    push_halt(9, 0);
    boot("++[>+<-]");
    run_to_halt("t_loop", 200, cyc);
    chk("t_loop_cell0", 32'(ram[0]), 32'h00);
    chk("t_loop_cell1", 32'(ram[1]), 32'h02);

    // "[+[+]]+" on zero cell: forward scan skips the nested loop.
    clear_ram_img();
    push_wr(0, 1);
    push_halt(8, 0);
    boot("[+[+]]+");
    run_to_halt("t_skip", 100, cyc);
    chk("t_skip_cell0", 32'(ram[0]), 32'h01);

    // Reset asserted during the EXEC of '+' aborts the write.
    clear_ram_img();
    ram_img[0] = 8'h05;
    boot("+");
    @(posedge clk);
    #1;
    chk("t_abort_in_exec", 32'(bus.probe), 32'd1);
    chk("t_abort_wr_before", 32'(bus.write_rq), 32'd1);
    reset = 1'b0;
    #1;
    chk("t_abort_wr_gated", 32'(bus.write_rq), 32'd0);
    chk("t_abort_data_gated", 32'(bus.data_out), 32'd0);
    @(posedge clk);
    #1;
    chk("t_abort_probe", 32'(bus.probe), 32'd0);
    chk("t_abort_pc", 32'(bus.addr_code), 32'd0);
    chk("t_abort_dp", 32'(bus.addr_array), 32'd0);
    chk("t_abort_cell0", 32'(ram[0]), 32'h05);

    // Unmatched '[' on zero cell: scan runs to PC 511 and halts without writes.
    clear_ram_img();
    push_halt(511, 0);
    boot("[");
    run_to_halt("t_unmatched", 2000, cyc);
    chk("t_unmatched_cycles", 32'(cyc), 32'd1024);
    nz = 0;
    for (int i = 0; i < 512; i++) if (ram[i] != 8'h00) nz++;
    chk("t_unmatched_ram", 32'(nz), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
